// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared glyph constants and BCD type for the 7-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    // Active-high glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver_if
// Brief    : Digit/control inputs and display outputs of the scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable_i;
    logic                    load_i;
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    lz_suppress_i;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;

    modport master (
        output enable_i, load_i, digits_i, dp_i, lz_suppress_i,
        input  seg_o, dp_o, an_o
    );

    modport slave (
        input  enable_i, load_i, digits_i, dp_i, lz_suppress_i,
        output seg_o, dp_o, an_o
    );
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : BCD to active-high 7-segment glyph; non-BCD codes show a dash.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = SEG_DASH;
        case (i_bcd)
            4'd0:    o_glyph = SEG_0;
            4'd1:    o_glyph = SEG_1;
            4'd2:    o_glyph = SEG_2;
            4'd3:    o_glyph = SEG_3;
            4'd4:    o_glyph = SEG_4;
            4'd5:    o_glyph = SEG_5;
            4'd6:    o_glyph = SEG_6;
            4'd7:    o_glyph = SEG_7;
            4'd8:    o_glyph = SEG_8;
            4'd9:    o_glyph = SEG_9;
            default: o_glyph = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed N-digit 7-segment driver with shadow register,
//            blanking, leading-zero suppression and one shared decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCNT_W = $clog2(PRESCALE);

    localparam logic [PCNT_W-1:0] c_pcnt_max = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] c_blank    = PCNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  c_idx_max  = IDX_W'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] r_shadow_digits;
    logic [NUM_DIGITS-1:0]      r_shadow_dp;
    logic [PCNT_W-1:0]          r_pcnt;
    logic [IDX_W-1:0]           r_idx;
    logic [6:0]                 r_seg;
    logic                       r_dp;
    logic [NUM_DIGITS-1:0]      r_an;

    bcd_t                       w_digit;
    logic [6:0]                 w_glyph;
    logic [NUM_DIGITS-1:0]      w_lz_mask;
    logic [6:0]                 w_seg_next;
    logic                       w_dp_next;
    logic [NUM_DIGITS-1:0]      w_an_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
        end else if (bus.load_i) begin
            r_shadow_digits <= bus.digits_i;
            r_shadow_dp     <= bus.dp_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (!bus.enable_i) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (r_pcnt == c_pcnt_max) begin
            r_pcnt <= '0;
            r_idx  <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // A digit is blanked while it and everything above it is zero; digit 0 always shows.
    always_comb begin
        logic w_run;
        w_run     = 1'b1;
        w_lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run        = w_run & (r_shadow_digits[k] == 4'd0);
            w_lz_mask[k] = bus.lz_suppress_i & w_run;
        end
    end

    assign w_digit = r_shadow_digits[r_idx];

    seg7_decode u_decode (
        .i_bcd   (w_digit),
        .o_glyph (w_glyph)
    );

    always_comb begin
        w_seg_next = SEG_OFF;
        w_dp_next  = 1'b0;
        w_an_next  = '0;
        if (bus.enable_i) begin
            w_seg_next = w_lz_mask[r_idx] ? SEG_OFF : w_glyph;
            w_dp_next  = r_shadow_dp[r_idx];
            if (r_pcnt >= c_blank) begin
                w_an_next[r_idx] = 1'b1;
            end
        end
    end

    // Held active-high so the asynchronous clear lands on "all dark" for any polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_dp  <= 1'b0;
            r_an  <= '0;
        end else begin
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.seg_o = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign bus.dp_o  = (SEG_ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign bus.an_o  = (AN_ACTIVE_LOW  != 0) ? ~r_an  : r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed self-checking bench for seg7_scan_driver (4 digits,
//            PRESCALE 8, BLANK_CYCLES 2, active-low segments and anodes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 8;
    localparam int BLANK      = 2;

    // Active-low glyph strings {digit3, digit2, digit1, digit0}
    localparam logic [27:0] c_g_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] c_g_0045 = {7'h7F, 7'h7F, 7'h19, 7'h12};
    localparam logic [27:0] c_g_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] c_g_00a0 = {7'h40, 7'h40, 7'h3F, 7'h40};
    localparam logic [27:0] c_g_9876 = {7'h10, 7'h00, 7'h78, 7'h02};
    localparam logic [27:0] c_g_zero = {7'h40, 7'h40, 7'h40, 7'h40};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS     (NUM_DIGITS),
        .PRESCALE       (PRESCALE),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_an"},  32'(bus.an_o),  32'h0F);
        check({tag, "_seg"}, 32'(bus.seg_o), 32'h7F);
        check({tag, "_dp"},  32'(bus.dp_o),  32'h1);
    endtask

    // Parks the scan at digit 0 while loading the shadow, then enables.
    task automatic start_scan(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus.enable_i      = 1'b0;
        bus.load_i        = 1'b1;
        bus.digits_i      = d;
        bus.dp_i          = dp;
        bus.lz_suppress_i = lz;
        tick();
        bus.load_i        = 1'b0;
        bus.enable_i      = 1'b1;
    endtask

    // Cycle t after enabling shows slot position t%8 of digit (t/8)%4.
    task automatic run_scan(input string tag, input int ncyc,
                            input logic [27:0] g, input logic [3:0] dpo);
        logic [3:0] exp_an;
        int p;
        int d;
        for (int t = 0; t < ncyc; t++) begin
            tick();
            p = t % PRESCALE;
            d = (t / PRESCALE) % NUM_DIGITS;
            if (p >= BLANK) begin
                exp_an    = 4'hF;
                exp_an[d] = 1'b0;
                check($sformatf("%s_an_t%0d", tag, t),  32'(bus.an_o),  32'(exp_an));
                check($sformatf("%s_seg_t%0d", tag, t), 32'(bus.seg_o), 32'(g[7*d +: 7]));
                check($sformatf("%s_dp_t%0d", tag, t),  32'(bus.dp_o),  32'(dpo[d]));
            end else begin
                check($sformatf("%s_blank_t%0d", tag, t), 32'(bus.an_o), 32'h0F);
            end
        end
    endtask

    initial begin
        int bad;
        rst_n             = 1'b0;
        bus.enable_i      = 1'b0;
        bus.load_i        = 1'b0;
        bus.digits_i      = '0;
        bus.dp_i          = '0;
        bus.lz_suppress_i = 1'b0;

        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.an_o !== 4'hF || bus.seg_o !== 7'h7F || bus.dp_o !== 1'b1) bad++;
        end
        check("idle_50", 32'(bad), 32'h0);

        start_scan(16'h1234, 4'b0000, 1'b0);
        run_scan("s1234", 64, c_g_1234, 4'b1111);

        start_scan(16'h0045, 4'b0100, 1'b1);
        run_scan("s0045", 32, c_g_0045, 4'b1011);

        start_scan(16'h0000, 4'b0000, 1'b1);
        run_scan("s0000", 32, c_g_0000, 4'b1111);

        start_scan(16'h00A0, 4'b0000, 1'b0);
        run_scan("s00a0", 32, c_g_00a0, 4'b1111);

        start_scan(16'h9876, 4'b0000, 1'b0);
        run_scan("s9876", 32, c_g_9876, 4'b1111);

        // Load during digit 0's lit window: old glyph at the load edge, new one after.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (4) tick();
        check("ml_pre_an",  32'(bus.an_o),  32'h0E);
        check("ml_pre_seg", 32'(bus.seg_o), 32'h19);
        bus.load_i   = 1'b1;
        bus.digits_i = 16'h1239;
        tick();
        bus.load_i   = 1'b0;
        check("ml_edge_seg", 32'(bus.seg_o), 32'h19);
        tick();
        check("ml_next_seg", 32'(bus.seg_o), 32'h10);
        check("ml_next_an",  32'(bus.an_o),  32'h0E);

        // Asynchronous reset while digit 2 is lit; shadow is cleared too.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (20) tick();
        check("pre_rst_an",  32'(bus.an_o),  32'h0B);
        check("pre_rst_seg", 32'(bus.seg_o), 32'h24);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        check_idle("rst_hold");
        rst_n = 1'b1;
        run_scan("post_rst", 16, c_g_zero, 4'b1111);

        // Drop enable while digit 1 is lit, then re-enable.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (12) tick();
        check("pre_drop_an", 32'(bus.an_o), 32'h0D);
        bus.enable_i = 1'b0;
        tick();
        check_idle("en_drop");
        repeat (3) tick();
        check_idle("en_low");
        bus.enable_i = 1'b1;
        run_scan("re_en", 16, c_g_1234, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode/common-cathode 7-segment display in the stopwatch datapath. It accepts packed BCD digits and decimal points, latches them into a shadow register on a load strobe, and scans the digits one at a time with a programmable dwell and inter-digit blanking. It adds leading-zero suppression and an error glyph for non-BCD codes. It replaces per-digit combinational decoders with one shared decoder and one registered output stage.

## Interface
- NUM_DIGITS, 4: digits scanned, legal range 1..8
- PRESCALE, 1000: clock cycles per digit slot, must be >= 2
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes inactive, must be < PRESCALE
- SEG_ACTIVE_LOW, 1: segment and dp polarity, 1 = low lights the segment
- AN_ACTIVE_LOW, 1: anode polarity, 1 = low selects the digit

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  scan enable
- load_i  in  1  one-cycle strobe; captures digits_i/dp_i into shadow
- digits_i  in  4*NUM_DIGITS  packed BCD, digit k at [4k+3:4k], digit 0 is rightmost/LSD
- dp_i  in  NUM_DIGITS  decimal point request per digit
- lz_suppress_i  in  1  enable leading-zero blanking
- seg_o  out  7  segments, bit0 = a … bit6 = g
- dp_o  out  1  decimal point segment
- an_o  out  NUM_DIGITS  digit selects

## Operation
- One clock; reset is asynchronous and active-low. All state is cleared when rst_n is low.
- Shadow register: on a clk edge with load_i=1, shadow_digits<=digits_i and shadow_dp<=dp_i. Reset value is 0. Load is honoured regardless of enable_i. Display reads only the shadow.
- Scan state: pcnt counts 0..PRESCALE-1 while enable_i=1. At pcnt=PRESCALE-1, pcnt->0 and idx->idx+1, with NUM_DIGITS-1 wrapping to 0.
- enable_i=0: pcnt and idx are held at 0. Next-cycle outputs are all inactive.
- Decode of the selected shadow digit:
  - 0-9: standard glyphs.
  - 10-15: dash (g only).
- Leading-zero suppression (lz_suppress_i=1): a digit is suppressed when it and every more-significant digit equal 0. Digit 0 is never suppressed. A suppressed digit drives segments off but still shows its dp, and its anode still asserts.
- Output stage, registered, computed from the current idx/pcnt:
  - an_o selects idx only when enable_i=1 and pcnt>=BLANK_CYCLES; otherwise all inactive.
  - seg_o/dp_o carry the decoded glyph of idx.
- Polarity is applied last, per parameter.

## Timing
- Reset: an_o all inactive (4'b1111 with defaults), seg_o all off (7'h7F), dp_o off (1). idx=0, pcnt=0, shadow=0.
- Outputs lag the scan state by exactly one cycle.
- First enabled edge after reset: pcnt=0, idx=0. The anode for digit 0 first asserts BLANK_CYCLES+1 edges later.
- Each slot: BLANK_CYCLES cycles with all anodes off, then PRESCALE-BLANK_CYCLES cycles with one anode on. Two anodes are never active in the same cycle.
- Full frame: NUM_DIGITS*PRESCALE cycles.
- load_i mid-slot: new value appears on seg_o two edges after the load edge (shadow, then output register). No tear guard beyond that.
- rst_n asserted mid-scan: outputs go inactive immediately (asynchronously). Scan restarts at digit 0 after release.
- enable_i falling: anodes inactive on the next edge. Rising: scan restarts at digit 0.

## Structure
- Package seg7_pkg holds:
  - active-high glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7-bit, bit0 = a);
  - a typedef for 4-bit BCD.
- Sub-module seg7_decode: combinational, BCD in, active-high 7-bit glyph out, 10-15 mapped to SEG_DASH. This is the only decoder instance; polarity inversion stays in the top level.
- Top level holds the shadow register, prescaler, index counter, suppression mask, and output register.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, and both polarities low.
- Reset held low -> an_o=4'b1111, seg_o=7'h7F, dp_o=1. Release with enable_i=0 -> outputs unchanged for 50 cycles.
- Load 16'h1234, dp_i=4'b0000, enable_i=1 -> digit 0 slot:
  - an_o=4'b1110 with seg_o=7'h19 ('4') for 6 cycles;
  - then 2 blank cycles (4'b1111);
  - then an_o=4'b1101 with seg_o=7'h30 ('3');
  - frame repeats every 32 cycles.
- Load 16'h0045, lz_suppress_i=1, dp_i=4'b0100 -> digit 3 shows segments off and dp off. Digit 2 shows segments off and dp_o=0. Digits 1/0 show '4'/'5'. Load 16'h0000 -> only digit 0 shows '0' (7'h40).
- Load 16'h00A0 -> digit 1 shows dash, seg_o=7'h3F.
- Reset pulse while idx=2 mid-slot -> outputs inactive in the same cycle. After release, digit 0 anode asserts first.
- Drop enable_i during digit 1 -> an_o=4'b1111 on the next edge. Re-enable -> digit 0 is scanned first, after 2 blank cycles.
